// File: rtl/ex_pipe.sv
// ex_pipe: single-issue RV execute stage with a registered output slot.
//   Single-cycle ALU / branch / jump / load-store address ops land in the
//   output register one cycle after acceptance. A taken branch or jump
//   raises a one-cycle fetch redirect and squashes the next KILL_SLOTS
//   accepted instructions (wrong-path fetches already in flight).
//   Optional feature macro: EX_PIPE_MUL_EN adds an iterative shift-add MUL
//   (XLEN busy cycles); without it every mext=1 OP instruction is unknown.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready          issue handshake
//   op, funct3, alt, mext      decoded opcode fields
//   n1, n2, imm, pc_tgt        operands, immediate, decode-computed target
//   wa, we                     destination register / write enable
//   out_valid/out_ready        result handshake
//   out_wa, out_we, out_res    writeback
//   out_mem_e {en,len,wr,uns}, out_mem_d   memory request
//   redir_valid, redir_pc      fetch redirect
//   busy                       multiplier running
module ex_pipe #(
  parameter int XLEN       = 32,
  parameter int KILL_SLOTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            mext,
  input  logic [XLEN-1:0] n1,
  input  logic [XLEN-1:0] n2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc_tgt,
  input  logic [4:0]      wa,
  input  logic            we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_wa,
  output logic            out_we,
  output logic [XLEN-1:0] out_res,
  output logic [4:0]      out_mem_e,
  output logic [XLEN-1:0] out_mem_d,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OPC_IMM = 7'b0010011, OPC_REG = 7'b0110011,
                         OPC_LUI = 7'b0110111, OPC_AUI = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BR  = 7'b1100011, OPC_LD = 7'b0000011,
                         OPC_ST  = 7'b0100011;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d, redir_valid_q, redir_valid_d;
  logic [4:0]        out_wa_q, out_wa_d, out_mem_e_q, out_mem_e_d;
  logic              out_we_q, out_we_d;
  logic [XLEN-1:0]   out_res_q, out_res_d, out_mem_d_q, out_mem_d_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic [2:0]        kill_q, kill_d;

  // Combinational execute results for the instruction on the inputs
  logic [XLEN-1:0]   res_c, mem_d_c, redir_pc_c, ea;
  logic [4:0]        mem_e_c;
  logic              we_c, redir_c, taken;
  logic              accept;

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic sub,
                                          input logic arith, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh  = b[SHW-1:0];
    alu = '0;
    case (f3)
      3'b000: alu = sub ? a - b : a + b;
      3'b001: alu = a << sh;
      3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011: alu = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100: alu = a ^ b;
      3'b101: begin
        // kept as separate assignments so >>> stays in a signed context
        if (arith) alu = $signed(a) >>> sh;
        else       alu = a >> sh;
      end
      3'b110: alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  assign ea       = n1 + imm;
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    case (funct3)
      3'b000:  taken = (n1 == n2);
      3'b001:  taken = (n1 != n2);
      3'b100:  taken = ($signed(n1) < $signed(n2));
      3'b101:  taken = !($signed(n1) < $signed(n2));
      3'b110:  taken = (n1 < n2);
      3'b111:  taken = !(n1 < n2);
      default: taken = 1'b0;
    endcase
  end

`ifdef EX_PIPE_MUL_EN
  logic              mul_c;
  logic [XLEN-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
`endif

  always_comb begin
    res_c      = '0;
    we_c       = we;
    mem_e_c    = '0;
    mem_d_c    = '0;
    redir_c    = 1'b0;
    redir_pc_c = '0;
`ifdef EX_PIPE_MUL_EN
    mul_c      = 1'b0;
`endif
    case (op)
      OPC_IMM: res_c = alu(funct3, 1'b0, alt, n1, n2);
      OPC_REG: begin
        if (mext) begin
`ifdef EX_PIPE_MUL_EN
          if (funct3 == 3'b000) mul_c = 1'b1;
          else                  we_c  = 1'b0;
`else
          we_c = 1'b0;
`endif
        end else begin
          res_c = alu(funct3, alt, alt, n1, n2);
        end
      end
      OPC_LUI, OPC_AUI: res_c = n2;
      OPC_JAL: begin
        res_c      = n2;
        redir_c    = 1'b1;
        redir_pc_c = pc_tgt;
      end
      OPC_JALR: begin
        res_c      = n2;
        redir_c    = 1'b1;
        redir_pc_c = {ea[XLEN-1:1], 1'b0};
      end
      OPC_BR: begin
        we_c       = 1'b0;
        redir_c    = taken;
        redir_pc_c = pc_tgt;
      end
      OPC_LD: begin
        res_c = ea;
        case (funct3)
          3'b000:  mem_e_c = 5'b1_00_0_0;
          3'b001:  mem_e_c = 5'b1_01_0_0;
          3'b010:  mem_e_c = 5'b1_11_0_0;
          3'b100:  mem_e_c = 5'b1_00_0_1;
          3'b101:  mem_e_c = 5'b1_01_0_1;
          default: mem_e_c = 5'b0;
        endcase
      end
      OPC_ST: begin
        res_c   = ea;
        we_c    = 1'b0;
        mem_d_c = n2;
        mem_e_c = {1'b1, (funct3[1] ? 2'b11 : {1'b0, funct3[0]}), 2'b10};
      end
      default: we_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q && !out_ready;
    redir_valid_d = 1'b0;
    out_wa_d      = out_wa_q;
    out_we_d      = out_we_q;
    out_res_d     = out_res_q;
    out_mem_e_d   = out_mem_e_q;
    out_mem_d_d   = out_mem_d_q;
    redir_pc_d    = redir_pc_q;
    kill_d        = kill_q;
`ifdef EX_PIPE_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (state_q == S_MUL) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == SHW'(XLEN-1)) begin
        out_res_d   = acc_d;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
    end
`endif
    if (accept) begin
      if (kill_q != '0) begin
        // wrong-path instruction: swallow it, never redirect from it
        kill_d = kill_q - 1'b1;
      end
`ifdef EX_PIPE_MUL_EN
      else if (mul_c) begin
        // output slot is free at this edge, so writeback tags can go now
        state_d     = S_MUL;
        mcand_d     = n1;
        mplier_d    = n2;
        acc_d       = '0;
        cnt_d       = '0;
        out_wa_d    = wa;
        out_we_d    = we_c;
        out_mem_e_d = '0;
        out_mem_d_d = '0;
      end
`endif
      else begin
        out_valid_d = 1'b1;
        out_wa_d    = wa;
        out_we_d    = we_c;
        out_res_d   = res_c;
        out_mem_e_d = mem_e_c;
        out_mem_d_d = mem_d_c;
        if (redir_c) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = redir_pc_c;
          kill_d        = 3'(KILL_SLOTS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      redir_valid_q <= 1'b0;
      out_wa_q      <= '0;
      out_we_q      <= 1'b0;
      out_res_q     <= '0;
      out_mem_e_q   <= '0;
      out_mem_d_q   <= '0;
      redir_pc_q    <= '0;
      kill_q        <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      redir_valid_q <= redir_valid_d;
      out_wa_q      <= out_wa_d;
      out_we_q      <= out_we_d;
      out_res_q     <= out_res_d;
      out_mem_e_q   <= out_mem_e_d;
      out_mem_d_q   <= out_mem_d_d;
      redir_pc_q    <= redir_pc_d;
      kill_q        <= kill_d;
    end
  end

`ifdef EX_PIPE_MUL_EN
  // multiplier working registers are only meaningful while in S_MUL
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
  end
  assign busy = (state_q == S_MUL);
`else
  assign busy = 1'b0;
`endif

  assign out_valid   = out_valid_q;
  assign redir_valid = redir_valid_q;
  assign out_wa      = out_wa_q;
  assign out_we      = out_we_q;
  assign out_res     = out_res_q;
  assign out_mem_e   = out_mem_e_q;
  assign out_mem_d   = out_mem_d_q;
  assign redir_pc    = redir_pc_q;
endmodule

// File: tb/tb_ex_pipe.sv
module tb_ex_pipe;
  localparam int XL = 32;
  localparam int KS = 1;
  localparam logic [6:0] O_IMM = 7'b0010011, O_REG = 7'b0110011, O_LUI = 7'b0110111,
                         O_AUI = 7'b0010111, O_JAL = 7'b1101111, O_JALR = 7'b1100111,
                         O_BR = 7'b1100011, O_LD = 7'b0000011, O_ST = 7'b0100011;
  localparam logic [6:0] OPS [11] = '{O_IMM, O_REG, O_LUI, O_AUI, O_JAL, O_JALR,
                                      O_BR, O_LD, O_ST, 7'b1111111, 7'b0001111};

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic alt = 1'b0, mext = 1'b0, we = 1'b0, out_we, redir_valid, busy;
  logic [XL-1:0] n1 = '0, n2 = '0, imm = '0, pc_tgt = '0;
  logic [XL-1:0] out_res, out_mem_d, redir_pc;
  logic [4:0] wa = '0, out_wa, out_mem_e;

  ex_pipe #(.XLEN(XL), .KILL_SLOTS(KS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .funct3(funct3), .alt(alt), .mext(mext), .n1(n1), .n2(n2), .imm(imm),
    .pc_tgt(pc_tgt), .wa(wa), .we(we), .out_valid(out_valid), .out_ready(out_ready),
    .out_wa(out_wa), .out_we(out_we), .out_res(out_res), .out_mem_e(out_mem_e),
    .out_mem_d(out_mem_d), .redir_valid(redir_valid), .redir_pc(redir_pc), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [XL-1:0] res;
    logic [4:0]    wa;
    logic          we;
    logic [4:0]    mem_e;
    logic [XL-1:0] mem_d;
    bit            redir;
    logic [XL-1:0] rpc;
    bit            mul;
  } item_t;

  item_t exp_q[$];
  item_t mul_item;
  bit exp_ov = 1'b0, exp_rv = 1'b0;
  logic [XL-1:0] exp_rpc = '0;
  int kill_m = 0, mul_left = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: what the execute stage must produce for the current inputs
  function automatic item_t ref_exec();
    item_t r;
    logic [4:0] sh;
    logic [XL-1:0] ea;
    longint sa;
    logic [63:0] prod;
    bit lt, ltu;
    r.res = '0; r.wa = wa; r.we = we; r.mem_e = '0; r.mem_d = '0;
    r.redir = 1'b0; r.rpc = '0; r.mul = 1'b0;
    sh = n2[4:0];
    ea = n1 + imm;
    lt = ($signed(n1) < $signed(n2));
    ltu = (n1 < n2);
    if (op == O_IMM || op == O_REG) begin
      if (op == O_REG && mext) begin
`ifdef EX_PIPE_MUL_EN
        if (funct3 == 3'd0) begin
          prod = {32'b0, n1} * {32'b0, n2};
          r.res = prod[XL-1:0];
          r.mul = 1'b1;
        end else r.we = 1'b0;
`else
        r.we = 1'b0;
`endif
      end else begin
        case (funct3)
          3'd0: r.res = (op == O_REG && alt) ? n1 - n2 : n1 + n2;
          3'd1: r.res = n1 << sh;
          3'd2: r.res = lt ? 1 : 0;
          3'd3: r.res = ltu ? 1 : 0;
          3'd4: r.res = n1 ^ n2;
          3'd5: begin
            sa = $signed(n1);
            sa = alt ? (sa >>> sh) : longint'(n1 >> sh);
            r.res = sa[XL-1:0];
          end
          3'd6: r.res = n1 | n2;
          default: r.res = n1 & n2;
        endcase
      end
    end else if (op == O_LUI || op == O_AUI) begin
      r.res = n2;
    end else if (op == O_JAL) begin
      r.res = n2; r.redir = 1'b1; r.rpc = pc_tgt;
    end else if (op == O_JALR) begin
      r.res = n2; r.redir = 1'b1; r.rpc = ea & ~32'h1;
    end else if (op == O_BR) begin
      r.we = 1'b0;
      r.rpc = pc_tgt;
      case (funct3)
        3'd0: r.redir = (n1 == n2);
        3'd1: r.redir = (n1 != n2);
        3'd4: r.redir = lt;
        3'd5: r.redir = !lt;
        3'd6: r.redir = ltu;
        3'd7: r.redir = !ltu;
        default: r.redir = 1'b0;
      endcase
    end else if (op == O_LD) begin
      r.res = ea;
      case (funct3)
        3'd0: r.mem_e = {1'b1, 2'd0, 1'b0, 1'b0};
        3'd1: r.mem_e = {1'b1, 2'd1, 1'b0, 1'b0};
        3'd2: r.mem_e = {1'b1, 2'd3, 1'b0, 1'b0};
        3'd4: r.mem_e = {1'b1, 2'd0, 1'b0, 1'b1};
        3'd5: r.mem_e = {1'b1, 2'd1, 1'b0, 1'b1};
        default: r.mem_e = '0;
      endcase
    end else if (op == O_ST) begin
      r.res = ea; r.we = 1'b0; r.mem_d = n2;
      r.mem_e = {1'b1, (funct3 == 3'd0) ? 2'd0 : (funct3 == 3'd1) ? 2'd1 : 2'd3, 1'b1, 1'b0};
    end else begin
      r.we = 1'b0;
    end
    return r;
  endfunction

  task automatic set_ins(input logic [6:0] o, input logic [2:0] f, input logic a,
                         input logic m, input logic [XL-1:0] x, input logic [XL-1:0] y,
                         input logic [XL-1:0] i, input logic [XL-1:0] t,
                         input logic [4:0] w, input logic e);
    op = o; funct3 = f; alt = a; mext = m; n1 = x; n2 = y; imm = i; pc_tgt = t;
    wa = w; we = e;
  endtask

  // One clock: check outputs against the scoreboard, then advance the model
  task automatic step(input bit iv, input bit ordy);
    item_t r;
    bit rdy, acc, new_ov, new_rv;
    logic [XL-1:0] new_rpc;
    in_valid = iv;
    out_ready = ordy;
    #1;
    rdy = (mul_left == 0) && (!exp_ov || ordy);
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, exp_ov);
    check("busy", busy, mul_left > 0);
    check("redir_valid", redir_valid, exp_rv);
    if (exp_rv) check("redir_pc", redir_pc, exp_rpc);
    if (exp_ov && exp_q.size() > 0) begin
      check("out_res", out_res, exp_q[0].res);
      check("out_wa", out_wa, exp_q[0].wa);
      check("out_we", out_we, exp_q[0].we);
      check("out_mem_e", out_mem_e, exp_q[0].mem_e);
      check("out_mem_d", out_mem_d, exp_q[0].mem_d);
    end
    acc = iv && rdy;
    new_ov = exp_ov && !ordy;
    new_rv = 1'b0;
    new_rpc = exp_rpc;
    if (exp_ov && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_q.push_back(mul_item);
        new_ov = 1'b1;
      end
    end else if (acc) begin
      if (kill_m > 0) kill_m--;
      else begin
        r = ref_exec();
        if (r.mul) begin
          mul_left = XL;
          mul_item = r;
        end else begin
          exp_q.push_back(r);
          new_ov = 1'b1;
          if (r.redir) begin
            new_rv = 1'b1;
            new_rpc = r.rpc;
            kill_m = KS;
          end
        end
      end
    end
    @(posedge clk);
    exp_ov = new_ov;
    exp_rv = new_rv;
    exp_rpc = new_rpc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_redir_valid", redir_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_wa", out_wa, 0);
    check("rst_out_we", out_we, 0);
    check("rst_out_mem_e", out_mem_e, 0);
    check("rst_out_mem_d", out_mem_d, 0);
    check("rst_redir_pc", redir_pc, 0);
    rst = 1'b1;
    exp_q.delete();
    exp_ov = 1'b0; exp_rv = 1'b0; kill_m = 0; mul_left = 0;
  endtask

  initial begin
    logic [6:0] o;
    logic [2:0] f;
    @(negedge clk);
    do_reset();

    // ADD 5 + 7
    set_ins(O_REG, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, '0, '0, 5'd3, 1'b1);
    step(1, 1);
    #1;
    check("d_add_valid", out_valid, 1);
    check("d_add_res", out_res, 32'd12);
    check("d_add_wa", out_wa, 5'd3);
    check("d_add_we", out_we, 1);

    // SRA by 4 (upper bits of n2 ignored)
    set_ins(O_REG, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h24, '0, '0, 5'd4, 1'b1);
    step(1, 1);
    #1 check("d_sra_res", out_res, 32'hF800_0000);

    // BEQ taken, next ADD squashed, following ADD normal
    set_ins(O_BR, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, '0, 32'h100, 5'd0, 1'b0);
    step(1, 1);
    #1;
    check("d_beq_rv", redir_valid, 1);
    check("d_beq_rpc", redir_pc, 32'h100);
    check("d_beq_we", out_we, 0);
    set_ins(O_REG, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, '0, '0, 5'd5, 1'b1);
    step(1, 1);
    #1 check("d_squash_ov", out_valid, 0);
    set_ins(O_REG, 3'd0, 1'b0, 1'b0, 32'd20, 32'd22, '0, '0, 5'd6, 1'b1);
    step(1, 1);
    #1;
    check("d_post_ov", out_valid, 1);
    check("d_post_res", out_res, 32'd42);

    // LHU and SW
    set_ins(O_LD, 3'd5, 1'b0, 1'b0, 32'h1000, '0, 32'd2, '0, 5'd7, 1'b1);
    step(1, 1);
    #1;
    check("d_lhu_res", out_res, 32'h1002);
    check("d_lhu_mem_e", out_mem_e, 5'b10101);
    set_ins(O_ST, 3'd2, 1'b0, 1'b0, 32'h2000, 32'hAB, 32'd4, '0, 5'd0, 1'b0);
    step(1, 1);
    #1;
    check("d_sw_mem_e", out_mem_e, 5'b11110);
    check("d_sw_mem_d", out_mem_d, 32'hAB);
    check("d_sw_we", out_we, 0);

    // Backpressure: result held for 3 cycles while the next op waits
    set_ins(O_REG, 3'd0, 1'b0, 1'b0, 32'd100, 32'd1, '0, '0, 5'd8, 1'b1);
    step(1, 1);
    set_ins(O_REG, 3'd4, 1'b0, 1'b0, 32'hF0, 32'h0F, '0, '0, 5'd9, 1'b1);
    repeat (3) step(1, 0);
    #1;
    check("d_bp_ready", in_ready, 0);
    check("d_bp_res", out_res, 32'd101);
    step(1, 1);
    #1 check("d_bp_next", out_res, 32'hFF);
    step(0, 1);

`ifdef EX_PIPE_MUL_EN
    set_ins(O_REG, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, '0, '0, 5'd10, 1'b1);
    step(1, 1);
    repeat (XL) step(0, 1);
    #1;
    check("d_mul_valid", out_valid, 1);
    check("d_mul_res", out_res, 32'hFFFF_FFFD);
    step(0, 1);
    step(1, 1);
    repeat (9) step(0, 1);
    do_reset();
    repeat (XL + 2) step(0, 1);
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      o = OPS[$urandom_range(0, 10)];
      f = 3'($urandom);
      if (o == O_ST) f = 3'($urandom_range(0, 2));
      set_ins(o, f, 1'($urandom), (o == O_REG) ? ($urandom_range(0, 3) == 0) : 1'b0,
              ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
              $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) n2 = n1;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    repeat (XL + 4) step(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter KILL_SLOTS, default 1, number of accepted instructions squashed after a redirect (1..7).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port in_valid / in_ready, input / output, 1 each, issue handshake.
REQ-006 SHALL have port op, input, 7, RV opcode; funct3, input, 3; alt, input, 1, funct7[5]; mext, input, 1, funct7[0].
REQ-007 SHALL have ports n1, n2, imm, input, XLEN each, operands (n2 = link value for JAL/JALR).
REQ-008 SHALL have port pc_tgt, input, XLEN, decode-computed branch/JAL target.
REQ-009 SHALL have ports wa, input, 5, and we, input, 1, destination register and write enable.
REQ-010 SHALL have ports out_valid / out_ready, output / input, 1 each, result handshake.
REQ-011 SHALL have ports out_wa, output, 5; out_we, output, 1; out_res, output, XLEN.
REQ-012 SHALL have ports out_mem_e, output, 5, {en, len[1:0], wr, uns}, and out_mem_d, output, XLEN, store data.
REQ-013 SHALL have ports redir_valid, output, 1, and redir_pc, output, XLEN, fetch redirect.
REQ-014 SHALL have port busy, output, 1, high while in MUL state.

Function
REQ-015 SHALL accept an instruction when in_valid and in_ready are both high; in_ready = (state == IDLE) and (!out_valid or out_ready).
REQ-016 SHALL present the result of a single-cycle op in the registered output stage one cycle after acceptance; outputs hold stable while out_valid and !out_ready.
REQ-017 SHALL compute for 0010011/0110011: ADD/SUB (SUB only for 0110011 with alt), SLL, SLT (signed), SLTU, XOR, OR, AND, SRL/SRA (alt), shift amount = n2[log2(XLEN)-1:0]; OP-IMM uses n2 as immediate.
REQ-018 SHALL set out_res = n2 for LUI, AUIPC, JAL, JALR.
REQ-019 SHALL assert redir_valid for one cycle, registered alongside out_valid, with redir_pc = pc_tgt for JAL and taken branches (BEQ, BNE, BLT, BGE, BLTU, BGEU), and (n1 + imm) with bit0 cleared for JALR.
REQ-020 SHALL for branches set out_res = 0 and out_we = 0; funct3 010/011 never redirect.
REQ-021 SHALL for loads set out_res = n1 + imm, out_mem_e = {1, len, 0, uns} with LB/LBU len 0, LH/LHU len 1, LW len 3, uns = funct3[2]; other funct3 gives out_mem_e = 0.
REQ-022 SHALL for stores set out_res = n1 + imm, out_mem_d = n2, out_mem_e = {1, len, 1, 0}, out_we = 0.
REQ-023 SHALL set out_mem_e = 0 for non-memory ops; unknown opcodes give out_res = 0, out_we = 0, out_valid = 1.
REQ-024 SHALL after issuing a redirect load the kill counter with KILL_SLOTS; each subsequently accepted instruction while counter > 0 is consumed with no output (out_valid stays low) and decrements the counter.
REQ-025 SHALL never redirect from a squashed instruction.
REQ-026 SHALL keep in_ready high and the counter unchanged when no instruction arrives (bubbles do not consume kill slots).

Reset
REQ-027 SHALL on rst low at a clock edge clear out_valid, redir_valid, busy, kill counter, state to IDLE, and out_wa, out_we, out_res, out_mem_e, out_mem_d, redir_pc to 0.
REQ-028 SHALL abort any in-flight MUL on reset with no output produced.

Configuration
REQ-029 SHALL with macro EX_PIPE_MUL_EN defined treat 0110011 with mext=1, funct3=000 as MUL: enter state MUL, shift-add one bit per cycle for XLEN cycles, busy high, in_ready low, then load low XLEN bits of n1*n2 to out_res with out_valid high (acceptance-to-out_valid latency XLEN+1 cycles), return to IDLE.
REQ-030 SHALL with EX_PIPE_MUL_EN undefined treat any mext=1 op as unknown (REQ-023); busy tied 0.

Verification
REQ-031 SHALL cover: ADD n1=5, n2=7, wa=3, we=1 -> next cycle out_valid=1, out_res=12, out_wa=3, out_we=1.
REQ-032 SHALL cover: SRA n1=0x80000000, n2=0x24 (XLEN=32) -> out_res=0xF8000000 (shift 4).
REQ-033 SHALL cover: BEQ n1=n2=9, pc_tgt=0x100, then ADD -> redir_valid=1, redir_pc=0x100; ADD squashed, no out_valid; following ADD output normally.
REQ-034 SHALL cover: LHU n1=0x1000, imm=2 -> out_res=0x1002, out_mem_e=5'b10101; SW n2=0xAB -> out_mem_e=5'b11110, out_mem_d=0xAB.
REQ-035 SHALL cover: out_ready held low 3 cycles with in_valid high -> in_ready=0, outputs stable, no instruction lost.
REQ-036 SHALL cover (EX_PIPE_MUL_EN): MUL 0xFFFFFFFF*3 -> busy 32 cycles, out_res=0xFFFFFFFD at cycle 33; rst low at cycle 10 -> no output, busy=0.
